// File: rtl/calc_pkg.sv
// Shared opcode, error-code and FSM-state definitions for the calculator op scheduler.
package calc_pkg;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_DIV0 = 2'b01;
   localparam logic [1:0] ERR_TMO  = 2'b10;
   localparam logic [1:0] ERR_ILL  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLR    = 3'd1,
      S_LAUNCH = 3'd2,
      S_WAIT   = 3'd3,
      S_RESP   = 3'd4
   } sched_state_t;

endpackage

// File: rtl/calc_sched_timer.sv
// Saturating WAIT-phase cycle counter; expired is high while the count sits at LIMIT-1.
// Zero latency on the flag; clear has priority over enable.
module calc_sched_timer #(
   parameter int LIMIT = 64
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int TW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

   logic [TW-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (RST || clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == TW'(LIMIT - 1));

endmodule

// File: rtl/calc_op_scheduler.sv
// Sequences one request at a time through clear/start/wait on the selected arithmetic unit.
// Accept->CLR->LAUNCH->WAIT, response one cycle after DONE; REQ_READY only in IDLE, response held until RSP_READY.
module calc_op_scheduler
   import calc_pkg::*;
#(
   parameter int W         = 8,
   parameter int NUM_UNITS = 4,
   parameter int DIV_IDX   = 3,
   parameter int TIMEOUT   = 64
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     REQ_VALID,
   output logic                     REQ_READY,
   input  logic [1:0]               REQ_OP,
   input  logic [W-1:0]             REQ_A,
   input  logic [W-1:0]             REQ_B,
   output logic [W-1:0]             OPA,
   output logic [W-1:0]             OPB,
   output logic [NUM_UNITS-1:0]     UNIT_RST,
   output logic [NUM_UNITS-1:0]     UNIT_START,
   input  logic [NUM_UNITS-1:0]     UNIT_DONE,
   input  logic [NUM_UNITS*2*W-1:0] UNIT_RES,
   output logic                     RSP_VALID,
   input  logic                     RSP_READY,
   output logic [2*W-1:0]           RSP_DATA,
   output logic [1:0]               RSP_ERR,
   output logic                     BUSY
);

   localparam logic [2:0]           NUM_U3   = 3'(NUM_UNITS);
   localparam logic [1:0]           DIV_SEL  = 2'(DIV_IDX);
   localparam logic [NUM_UNITS-1:0] ONE_HOT0 = NUM_UNITS'(1);

   sched_state_t         state;
   logic [1:0]           sel;
   logic [NUM_UNITS-1:0] unit_rst_q;
   logic [NUM_UNITS-1:0] unit_start_q;
   logic [NUM_UNITS-1:0] sel_mask;
   logic                 done_sel;
   logic [2*W-1:0]       res_sel;
   logic                 tmr_exp;

   // Only the selected unit's DONE and result are ever looked at.
   assign sel_mask = ONE_HOT0 << sel;
   assign done_sel = |(UNIT_DONE & sel_mask);

   always_comb begin
      res_sel = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (sel == 2'(i)) res_sel = UNIT_RES[i*2*W +: 2*W];
      end
   end

   calc_sched_timer #(.LIMIT(TIMEOUT)) u_timer (
      .CLK     (CLK),
      .RST     (RST),
      .clr     (state == S_LAUNCH),
      .en      (state == S_WAIT),
      .expired (tmr_exp)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= S_IDLE;
         sel          <= '0;
         OPA          <= '0;
         OPB          <= '0;
         unit_rst_q   <= '0;
         unit_start_q <= '0;
         RSP_VALID    <= 1'b0;
         RSP_DATA     <= '0;
         RSP_ERR      <= ERR_OK;
      end else begin
         unit_rst_q   <= '0;
         unit_start_q <= '0;
         case (state)
            S_IDLE: begin
               if (REQ_VALID) begin
                  OPA <= REQ_A;
                  OPB <= REQ_B;
                  sel <= REQ_OP;
                  if ({1'b0, REQ_OP} >= NUM_U3) begin
                     state     <= S_RESP;
                     RSP_VALID <= 1'b1;
                     RSP_DATA  <= '0;
                     RSP_ERR   <= ERR_ILL;
                  end else if ((REQ_OP == DIV_SEL) && (REQ_B == '0)) begin
                     state     <= S_RESP;
                     RSP_VALID <= 1'b1;
                     RSP_DATA  <= '0;
                     RSP_ERR   <= ERR_DIV0;
                  end else begin
                     state      <= S_CLR;
                     unit_rst_q <= ONE_HOT0 << REQ_OP;
                  end
               end
            end
            S_CLR: begin
               state        <= S_LAUNCH;
               unit_start_q <= sel_mask;
            end
            S_LAUNCH: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               // DONE beats a simultaneous timeout.
               if (done_sel) begin
                  state     <= S_RESP;
                  RSP_VALID <= 1'b1;
                  RSP_DATA  <= res_sel;
                  RSP_ERR   <= ERR_OK;
               end else if (tmr_exp) begin
                  state     <= S_RESP;
                  RSP_VALID <= 1'b1;
                  RSP_DATA  <= '0;
                  RSP_ERR   <= ERR_TMO;
               end
            end
            S_RESP: begin
               if (RSP_READY) begin
                  state     <= S_IDLE;
                  RSP_VALID <= 1'b0;
               end
            end
            default: begin
               state     <= S_IDLE;
               RSP_VALID <= 1'b0;
            end
         endcase
      end
   end

   assign UNIT_RST   = unit_rst_q | {NUM_UNITS{RST}};
   assign UNIT_START = unit_start_q;
   assign REQ_READY  = (state == S_IDLE) && !RST;
   assign BUSY       = (state != S_IDLE);

endmodule
